// File: rtl/ccd_pattern_gen.sv
// CCD sensor-style test-pattern source: FVAL/LVAL framing with four selectable
// pixel patterns, a completed-frame counter and frame-boundary stop handling.
module ccd_pattern_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 1024,
  parameter int H_BLANK  = 64,
  parameter int V_BLANK  = 200,
  parameter int FV_TO_LV = 8
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iSTART,
  input  logic        iSTOP,
  input  logic [1:0]  iMODE,
  input  logic [9:0]  iLEVEL,
  output logic        oFVAL,
  output logic        oLVAL,
  output logic [9:0]  oDATA,
  output logic [31:0] oFrame_Cont,
  output logic        oBusy
);

  localparam logic [15:0] FRONT_END = 16'(FV_TO_LV - 1);
  localparam logic [15:0] HBL_END   = 16'(H_BLANK - 1);
  localparam logic [15:0] VBL_END   = 16'(V_BLANK - 1);
  localparam logic [10:0] X_END     = 11'(H_ACTIVE - 1);
  localparam logic [10:0] Y_END     = 11'(V_ACTIVE - 1);

  typedef enum logic [2:0] {
    IDLE,
    FRONT,
    LINE,
    HBLANK,
    VBLANK
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q;
  logic [10:0] x_q, y_q;
  logic [1:0]  mode_q;
  logic [9:0]  level_q;
  logic        stop_q, stop_d;

  // Stop request seen this cycle counts at the VBLANK exit decision too,
  // so a stop in the final blanking cycle is not lost.
  always_comb begin
    stop_d = stop_q;
    if (state_q != IDLE) begin
      if (iSTOP)       stop_d = 1'b1;
      else if (iSTART) stop_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (iSTART && !iSTOP) state_d = FRONT;
      FRONT:   if (cnt_q == FRONT_END) state_d = LINE;
      LINE:    if (x_q == X_END) state_d = (y_q == Y_END) ? VBLANK : HBLANK;
      HBLANK:  if (cnt_q == HBL_END) state_d = LINE;
      VBLANK:  if (cnt_q == VBL_END) state_d = stop_d ? IDLE : FRONT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      mode_q      <= '0;
      level_q     <= '0;
      stop_q      <= 1'b0;
      oFrame_Cont <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 16'd1;
      x_q     <= (state_q == LINE && state_d == LINE) ? x_q + 11'd1 : '0;
      if (state_q == FRONT)
        y_q <= '0;
      else if (state_q == HBLANK && state_d == LINE)
        y_q <= y_q + 11'd1;
      if (state_d == FRONT && state_q != FRONT) begin
        mode_q  <= iMODE;
        level_q <= iLEVEL;
      end
      stop_q <= (state_d == IDLE) ? 1'b0 : stop_d;
      if (state_q == LINE && state_d == VBLANK)
        oFrame_Cont <= oFrame_Cont + 32'd1;
    end
  end

  always_comb begin
    oFVAL = (state_q == FRONT) || (state_q == LINE) || (state_q == HBLANK);
    oLVAL = (state_q == LINE);
    oBusy = (state_q != IDLE);
    oDATA = '0;
    if (state_q == LINE) begin
      unique case (mode_q)
        2'd0:    oDATA = x_q[9:0];
        2'd1:    oDATA = y_q[9:0];
        2'd2:    oDATA = level_q;
        default: oDATA = {10{x_q[3] ^ y_q[3]}};
      endcase
    end
  end

endmodule

// File: tb/tb_ccd_pattern_gen.sv
// Scoreboarded bench for ccd_pattern_gen with a small frame geometry
// (4x3 active, 2 HBLANK, 5 VBLANK, 1 front-porch cycle).
module tb_ccd_pattern_gen;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iSTART = 1'b0;
  logic        iSTOP = 1'b0;
  logic [1:0]  iMODE = 2'd0;
  logic [9:0]  iLEVEL = 10'd0;
  logic        oFVAL, oLVAL, oBusy;
  logic [9:0]  oDATA;
  logic [31:0] oFrame_Cont;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [9:0] exp_q[$];

  ccd_pattern_gen #(
    .H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(2), .V_BLANK(5), .FV_TO_LV(1)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iSTART(iSTART), .iSTOP(iSTOP),
    .iMODE(iMODE), .iLEVEL(iLEVEL), .oFVAL(oFVAL), .oLVAL(oLVAL),
    .oDATA(oDATA), .oFrame_Cont(oFrame_Cont), .oBusy(oBusy)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge iCLK);
    #1;
    cyc++;
  endtask

  task automatic push_line(input logic [9:0] a, input logic [9:0] b,
                           input logic [9:0] c, input logic [9:0] d);
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
  endtask

  task automatic do_reset;
    iRST_N = 1'b0;
    #1;
    chk("rst_fval", 32'(oFVAL), 0);
    chk("rst_lval", 32'(oLVAL), 0);
    chk("rst_data", 32'(oDATA), 0);
    chk("rst_count", oFrame_Cont, 0);
    chk("rst_busy", 32'(oBusy), 0);
    exp_q.delete();
    repeat (3) tick;
    iRST_N = 1'b1;
    tick;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 200 && oBusy; i++) tick;
    chk("idle_timeout", 32'(oBusy), 0);
  endtask

  // Monitor: pops one expected pixel for every cycle the DUT presents LVAL,
  // and watches the FVAL/LVAL/DATA relationship on every cycle.
  always @(negedge iCLK) begin
    if (iRST_N) begin
      checks++;
      if (oLVAL && !oFVAL) begin
        errors++;
        $display("FAIL lval_without_fval at cycle %0d", cyc);
      end
      checks++;
      if (!oLVAL && oDATA != 10'd0) begin
        errors++;
        $display("FAIL data_outside_lval at cycle %0d: got %0h expected 0", cyc, oDATA);
      end
      if (oLVAL) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel at cycle %0d: got %0h", cyc, oDATA);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if (oDATA !== e) begin
            errors++;
            $display("FAIL pixel at cycle %0d: got %0h expected %0h", cyc, oDATA, e);
          end
        end
      end
    end
  end

  initial begin
    logic fv_exp, lv_exp;
    do_reset;

    // Mode 0 timing: FVAL 1..17, LVAL 2-5/8-11/14-17, next FVAL at 23.
    repeat (3) push_line(10'd0, 10'd1, 10'd2, 10'd3);
    exp_q.push_back(10'd0);
    iMODE = 2'd0;
    cyc = 0;
    iSTART = 1'b1;
    tick;
    iSTART = 1'b0;
    while (cyc <= 23) begin
      fv_exp = (cyc <= 17) || (cyc == 23);
      lv_exp = (cyc >= 2 && cyc <= 5) || (cyc >= 8 && cyc <= 11) || (cyc >= 14 && cyc <= 17);
      chk("t1_fval", 32'(oFVAL), 32'(fv_exp));
      chk("t1_lval", 32'(oLVAL), 32'(lv_exp));
      if (cyc == 17) chk("t1_count_before", oFrame_Cont, 0);
      if (cyc == 18) chk("t1_count_after", oFrame_Cont, 1);
      if (cyc == 20) chk("t1_busy_vblank", 32'(oBusy), 1);
      tick;
    end
    // Cycle 24 is the first pixel of frame 2; abort it with reset at cycle 25.
    tick;
    iRST_N = 1'b0;
    #1;
    chk("t1_abort_fval", 32'(oFVAL), 0);
    chk("t1_abort_lval", 32'(oLVAL), 0);
    chk("t1_abort_data", 32'(oDATA), 0);
    chk("t1_abort_count", oFrame_Cont, 0);
    chk("t1_pixels_drained", exp_q.size(), 0);
    exp_q.delete();
    tick;
    iRST_N = 1'b1;
    repeat (8) begin
      tick;
      chk("t1_stay_idle", 32'(oBusy), 0);
    end

    // Mode 2: level latched at frame start, change takes effect next frame.
    repeat (3) push_line(10'h155, 10'h155, 10'h155, 10'h155);
    repeat (3) push_line(10'h0AA, 10'h0AA, 10'h0AA, 10'h0AA);
    iMODE = 2'd2;
    iLEVEL = 10'h155;
    cyc = 0;
    iSTART = 1'b1;
    tick;
    iSTART = 1'b0;
    while (cyc < 5) tick;
    iLEVEL = 10'h0AA;
    iMODE = 2'd0;
    while (cyc < 22) tick;
    iMODE = 2'd2;
    while (cyc < 30) tick;
    iSTOP = 1'b1;
    tick;
    iSTOP = 1'b0;
    wait_idle;
    chk("t2_count", oFrame_Cont, 2);
    chk("t2_pixels_drained", exp_q.size(), 0);

    // Mode 1 with stop during the second line: frame completes, then idle.
    do_reset;
    push_line(10'd0, 10'd0, 10'd0, 10'd0);
    push_line(10'd1, 10'd1, 10'd1, 10'd1);
    push_line(10'd2, 10'd2, 10'd2, 10'd2);
    iMODE = 2'd1;
    cyc = 0;
    iSTART = 1'b1;
    tick;
    iSTART = 1'b0;
    while (cyc < 9) tick;
    iSTOP = 1'b1;
    tick;
    iSTOP = 1'b0;
    while (cyc < 18) tick;
    chk("t3_fval_vblank", 32'(oFVAL), 0);
    chk("t3_count", oFrame_Cont, 1);
    chk("t3_busy_vb_first", 32'(oBusy), 1);
    while (cyc < 22) tick;
    chk("t3_busy_vb_last", 32'(oBusy), 1);
    tick;
    chk("t3_busy_done", 32'(oBusy), 0);
    repeat (10) begin
      chk("t3_no_more_fval", 32'(oFVAL), 0);
      tick;
    end
    chk("t3_pixels_drained", exp_q.size(), 0);

    // Start+stop together while idle; stop then start while running.
    do_reset;
    cyc = 0;
    iSTART = 1'b1;
    iSTOP = 1'b1;
    tick;
    iSTART = 1'b0;
    iSTOP = 1'b0;
    chk("t4_both_idle_1", 32'(oBusy), 0);
    tick;
    chk("t4_both_idle_2", 32'(oBusy), 0);
    repeat (6) push_line(10'd0, 10'd0, 10'd0, 10'd0);
    iMODE = 2'd3;
    cyc = 0;
    iSTART = 1'b1;
    tick;
    iSTART = 1'b0;
    while (cyc < 3) tick;
    iSTOP = 1'b1;
    tick;
    iSTOP = 1'b0;
    tick;
    iSTART = 1'b1;
    tick;
    iSTART = 1'b0;
    while (cyc < 23) tick;
    chk("t4_continue_fval", 32'(oFVAL), 1);
    chk("t4_continue_busy", 32'(oBusy), 1);
    while (cyc < 30) tick;
    iSTART = 1'b1;
    iSTOP = 1'b1;
    tick;
    iSTART = 1'b0;
    iSTOP = 1'b0;
    wait_idle;
    chk("t4_count", oFrame_Cont, 2);
    chk("t4_pixels_drained", exp_q.size(), 0);
    repeat (4) tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ccd_pattern_gen.md
CCD_PATTERN_GEN -- requirements
Module: ccd_pattern_gen

Interface
REQ-001 Parameter H_ACTIVE, 1280, active pixels per line (range 1..2047).
REQ-002 Parameter V_ACTIVE, 1024, active lines per frame (range 1..2047).
REQ-003 Parameter H_BLANK, 64, LVAL-low cycles between consecutive lines, FVAL high (range 1..255).
REQ-004 Parameter V_BLANK, 200, FVAL-low cycles between frames (range 1..65535).
REQ-005 Parameter FV_TO_LV, 8, cycles from FVAL rise to first LVAL rise (range 1..255).
REQ-006 iCLK  in  1  single clock, pixel-clock domain; all outputs registered on its rising edge.
REQ-007 iRST_N  in  1  asynchronous, active-low reset.
REQ-008 iSTART  in  1  one-cycle start request.
REQ-009 iSTOP  in  1  one-cycle stop request, honoured at frame boundary.
REQ-010 iMODE  in  2  pattern select.
REQ-011 iLEVEL  in  10  constant level for mode 2.
REQ-012 oFVAL  out  1  frame valid, sensor-compatible.
REQ-013 oLVAL  out  1  line valid, high only while oFVAL high.
REQ-014 oDATA  out  10  raw pixel; meaningful only while oLVAL high, else 0.
REQ-015 oFrame_Cont  out  32  completed-frame count.
REQ-016 oBusy  out  1  high in any state other than IDLE.

Function
REQ-017 States SHALL be IDLE, FRONT, LINE, HBLANK, VBLANK; outputs decode from the registered state.
REQ-018 IDLE: oFVAL=0, oLVAL=0; iSTART=1 and iSTOP=0 -> FRONT on next edge (oFVAL rises 1 cycle after iSTART sampled).
REQ-019 FRONT: oFVAL=1, oLVAL=0 for exactly FV_TO_LV cycles -> LINE; iMODE and iLEVEL SHALL be latched on FRONT entry and held for the whole frame.
REQ-020 LINE: oFVAL=1, oLVAL=1 for exactly H_ACTIVE cycles; 11-bit X counter 0..H_ACTIVE-1, Y counter 0..V_ACTIVE-1.
REQ-021 After LINE: Y<V_ACTIVE-1 -> HBLANK (H_BLANK cycles, oFVAL=1, oLVAL=0) -> LINE with Y+1, X=0; Y=V_ACTIVE-1 -> VBLANK directly (oFVAL falls the cycle after the last pixel).
REQ-022 oFVAL high length per frame SHALL be FV_TO_LV + V_ACTIVE*H_ACTIVE + (V_ACTIVE-1)*H_BLANK cycles.
REQ-023 VBLANK: oFVAL=0 for exactly V_BLANK cycles, then FRONT if no stop pending, else IDLE.
REQ-024 oFrame_Cont SHALL increment by 1 on the cycle entering VBLANK; wraps 0xFFFFFFFF -> 0.
REQ-025 Data, latched mode: 0 -> X[9:0]; 1 -> Y[9:0]; 2 -> latched iLEVEL; 3 -> 10'h3FF if X[3]^Y[3] else 10'h000.
REQ-026 iSTOP while oBusy sets a sticky stop-pending flag; current frame always completes in full, incl. VBLANK.
REQ-027 iSTART while busy SHALL clear stop-pending; iSTART and iSTOP same cycle -> stop wins (set pending if busy, stay IDLE if idle).
REQ-028 iSTOP in IDLE SHALL have no effect; iSTART in non-IDLE states SHALL not restart timing.
REQ-029 oLVAL SHALL never be high while oFVAL is low; oDATA SHALL be 0 whenever oLVAL is 0.

Reset
REQ-030 iRST_N low SHALL immediately force IDLE, oFVAL=0, oLVAL=0, oDATA=0, oFrame_Cont=0, oBusy=0, stop-pending=0, X=Y=0, latched mode=0, latched level=0.
REQ-031 Reset mid-frame SHALL abort the frame without incrementing oFrame_Cont; after release, block stays IDLE until iSTART.

Verification (H_ACTIVE=4, V_ACTIVE=3, H_BLANK=2, V_BLANK=5, FV_TO_LV=1)
REQ-032 iSTART pulse at cycle 0, iMODE=0 -> oFVAL high cycles 1..17, oLVAL high cycles 2-5, 8-11, 14-17, oDATA 0,1,2,3 per line, oFVAL low 18..22, FVAL rises again at 23.
REQ-033 iMODE=2, iLEVEL=10'h155, iLEVEL changed to 10'h0AA mid-frame -> all active pixels 10'h155 in that frame, 10'h0AA in next.
REQ-034 iSTOP pulse during the second line of frame 1 -> frame completes, oFrame_Cont=1, oBusy falls after 5 VBLANK cycles, no further FVAL.
REQ-035 iSTART and iSTOP same cycle in IDLE -> oBusy stays 0; iSTOP then iSTART while running -> generation continues.
REQ-036 iRST_N low during LINE of frame 2 -> oFVAL/oLVAL/oDATA 0 asynchronously, oFrame_Cont=0, IDLE after release.
REQ-037 Checker: throughout all tests, oLVAL never high with oFVAL low; oDATA=0 whenever oLVAL low.
